wb_slave_mem: RTL and testbench
===============================

WB_SLAVE_MEM -- requirements
Module: wb_slave_mem

Interface
REQ-001 SHALL have parameter MEM_AW, default 10, meaning word-address width (memory depth 2**MEM_AW 32-bit words).
REQ-002 SHALL have parameter WAIT_STATES, default 2, range 0..15, meaning extra cycles inserted before each response.
REQ-003 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
REQ-005 SHALL have port wb_adr_i  input  32  byte address from the interconnect slave port.
REQ-006 SHALL have port wb_dat_i  input  32  write data.
REQ-007 SHALL have port wb_sel_i  input  4  byte-lane selects; bit n covers dat[8n+7:8n].
REQ-008 SHALL have port wb_we_i  input  1  1 = write, 0 = read.
REQ-009 SHALL have port wb_cyc_i  input  1  bus cycle valid.
REQ-010 SHALL have port wb_stb_i  input  1  strobe; a request is cyc & stb.
REQ-011 SHALL have port busy_i  input  1  backpressure; when high at request sample, the request is answered with retry.
REQ-012 SHALL have port wb_dat_o  output  32  read data.
REQ-013 SHALL have port wb_ack_o  output  1  normal termination.
REQ-014 SHALL have port wb_err_o  output  1  error termination.
REQ-015 SHALL have port wb_rty_o  output  1  retry termination.

Function
REQ-016 SHALL implement FSM IDLE, WAIT, RESP; IDLE->WAIT on request when WAIT_STATES>0, IDLE->RESP on request when WAIT_STATES=0, WAIT->RESP when wait counter reaches WAIT_STATES, RESP->IDLE unconditionally.
REQ-017 SHALL, for a request sampled in IDLE at edge k, assert exactly one of ack/err/rty for exactly the one cycle following edge k+WAIT_STATES.
REQ-018 SHALL hold ack, err and rty low in every cycle outside RESP, so at least one idle cycle separates consecutive terminations.
REQ-019 SHALL classify at the sample edge: rty if busy_i=1; otherwise err if wb_adr_i[1:0]!=0, wb_sel_i==0, or wb_adr_i[27:MEM_AW+2]!=0; otherwise ack.
REQ-020 SHALL latch address, data, sel and we at the sample edge; inputs changing during WAIT have no effect.
REQ-021 SHALL commit an acked write at the edge entering RESP, updating only the lanes with sel=1.
REQ-022 SHALL never modify memory on err, rty or aborted cycles.
REQ-023 SHALL load wb_dat_o from memory at the edge entering RESP for an acked read and hold it until the next acked read.
REQ-024 SHALL treat stb or cyc going low during WAIT as an abort: return to IDLE next edge with no termination.
REQ-025 SHALL, for a write followed immediately by a read of the same word, return the newly written data.

Reset
REQ-026 SHALL, when rst=0 at an edge, force state IDLE, wait counter 0, ack/err/rty 0 and wb_dat_o 32'h0, including mid-transaction (no termination for the interrupted request and no memory write).
REQ-027 SHALL leave memory contents unaffected by reset.

Structure
REQ-028 SHALL place the FSM state enum and the response enum (NONE, ACK, ERR, RTY) in shared package wb_mem_pkg.
REQ-029 SHALL instantiate one sub-module, wb_mem_array: a 2**MEM_AW x 32 synchronous memory with per-byte write enables, single port.

Verification
REQ-030 SHALL be checked as follows: write 0xDEADBEEF to 0x10 with sel=4'hF, then read 0x10 with WAIT_STATES=2 -> ack 3 cycles after each sample and read data 0xDEADBEEF.
REQ-031 SHALL be checked as follows: after REQ-030, write 0x000000AA to 0x10 with sel=4'b0001 -> read returns 0xDEADBEAA.
REQ-032 SHALL be checked as follows: read 0x12 (misaligned), then write with sel=0 -> err pulse for each, memory unchanged.
REQ-033 SHALL be checked as follows: write with busy_i=1 -> rty pulse, no ack; retry with busy_i=0 -> ack and data committed.
REQ-034 SHALL be checked as follows: drop stb one cycle after the sample with WAIT_STATES=3 -> no termination, FSM IDLE, target word unchanged.
REQ-035 SHALL be checked as follows: assert rst=0 during WAIT of a write -> no ack, outputs 0 the cycle after, prior memory data intact.

Source files
------------

// File: rtl/wb_mem_pkg.sv
// Shared types and helpers for the Wishbone slave memory: FSM states,
// termination kinds and the request classifier.
package wb_mem_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_e;

    typedef enum logic [1:0] {
        NONE,
        ACK,
        ERR,
        RTY
    } resp_e;

    // Byte-address bits [27:lo] that must be zero for an in-range access.
    function automatic logic [31:0] hi_addr_mask(input int lo);
        logic [31:0] m;
        m = '0;
        for (int i = 0; i < 28; i++) begin
            if (i >= lo) m[i] = 1'b1;
        end
        return m;
    endfunction

    function automatic resp_e classify(input logic [31:0] adr,
                                       input logic [3:0]  sel,
                                       input logic        busy,
                                       input logic [31:0] hi_mask);
        if (busy) return RTY;
        if (adr[1:0] != 2'b00 || sel == 4'h0 || (adr & hi_mask) != 32'h0) return ERR;
        return ACK;
    endfunction

endpackage

// File: rtl/wb_slave_mem_if.sv
// Wishbone classic slave-port bundle; names follow the slave's view (_i in, _o out).
interface wb_slave_mem_if;

    logic [31:0] wb_adr_i;
    logic [31:0] wb_dat_i;
    logic [3:0]  wb_sel_i;
    logic        wb_we_i;
    logic        wb_cyc_i;
    logic        wb_stb_i;
    logic [31:0] wb_dat_o;
    logic        wb_ack_o;
    logic        wb_err_o;
    logic        wb_rty_o;

    modport slave (
        input  wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_cyc_i, wb_stb_i,
        output wb_dat_o, wb_ack_o, wb_err_o, wb_rty_o
    );

    modport master (
        output wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_cyc_i, wb_stb_i,
        input  wb_dat_o, wb_ack_o, wb_err_o, wb_rty_o
    );

endinterface

// File: rtl/wb_mem_array.sv
// Single-port 2**AW x 32 synchronous RAM with per-byte write enables and a
// registered, hold-until-next-read output.
module wb_mem_array #(
    parameter int AW = 10
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] addr,
    input  logic [3:0]    be,
    input  logic [31:0]   wdata,
    input  logic          rd_en,
    output logic [31:0]   rdata
);

    logic [31:0] mem [2**AW];

    // NOTE: the storage array has no reset; contents must survive rst and a
    // reset loop over 2**AW words would stop the array mapping onto RAM.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst)       rdata <= 32'h0;
        else if (rd_en) rdata <= mem[addr];
    end

endmodule

// File: rtl/wb_slave_mem.sv
// Wishbone slave fronting a word memory: classifies each request at the sample
// edge, waits WAIT_STATES cycles, then emits a single ack/err/rty pulse.
module wb_slave_mem
    import wb_mem_pkg::*;
#(
    parameter int MEM_AW      = 10,
    parameter int WAIT_STATES = 2
) (
    input logic           clk,
    input logic           rst,
    input logic           busy_i,
    wb_slave_mem_if.slave wb
);

    localparam logic [3:0]  WS      = 4'(WAIT_STATES);
    localparam logic [31:0] HI_MASK = hi_addr_mask(MEM_AW + 2);

    state_e            state, state_nxt;
    logic [3:0]        cnt;
    logic [MEM_AW-1:0] adr_q;
    logic [31:0]       dat_q;
    logic [3:0]        sel_q;
    logic              we_q;
    resp_e             resp_q;

    logic              req, sample, commit, mem_rd;
    resp_e             live_resp, cur_resp;
    logic [MEM_AW-1:0] cur_adr;
    logic [31:0]       cur_dat;
    logic [3:0]        cur_sel, mem_be;
    logic              cur_we;
    logic [31:0]       rdata;

    assign req       = wb.wb_cyc_i & wb.wb_stb_i;
    assign sample    = (state == IDLE) && req;
    assign live_resp = classify(wb.wb_adr_i, wb.wb_sel_i, busy_i, HI_MASK);

    // With zero wait states the commit edge is the sample edge, so the live
    // bus values are used until the captured copies exist.
    assign cur_resp = (state == IDLE) ? live_resp                   : resp_q;
    assign cur_adr  = (state == IDLE) ? wb.wb_adr_i[MEM_AW+1:2]     : adr_q;
    assign cur_dat  = (state == IDLE) ? wb.wb_dat_i                 : dat_q;
    assign cur_sel  = (state == IDLE) ? wb.wb_sel_i                 : sel_q;
    assign cur_we   = (state == IDLE) ? wb.wb_we_i                  : we_q;

    assign commit = rst && (state_nxt == RESP) && (state != RESP) && (cur_resp == ACK);
    assign mem_be = (commit && cur_we) ? cur_sel : 4'h0;
    assign mem_rd = commit && !cur_we;

    // NOTE: every output of this block gets a default before the case so no
    // path leaves one unassigned, which would infer a latch.
    always_comb begin
        state_nxt   = state;
        wb.wb_ack_o = 1'b0;
        wb.wb_err_o = 1'b0;
        wb.wb_rty_o = 1'b0;
        case (state)
            IDLE: if (req) state_nxt = (WAIT_STATES == 0) ? RESP : WAIT;
            WAIT: begin
                if (!req)           state_nxt = IDLE;
                else if (cnt == WS) state_nxt = RESP;
            end
            RESP: begin
                state_nxt   = IDLE;
                wb.wb_ack_o = (resp_q == ACK);
                wb.wb_err_o = (resp_q == ERR);
                wb.wb_rty_o = (resp_q == RTY);
            end
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // sees the pre-edge values of the others, independent of statement order.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= 4'h0;
        end else begin
            state <= state_nxt;
            cnt   <= (state_nxt == WAIT) ? cnt + 4'h1 : 4'h0;
        end
    end

    // Captured request; only read after a sample, so no reset is needed.
    always_ff @(posedge clk) begin
        if (sample) begin
            adr_q  <= wb.wb_adr_i[MEM_AW+1:2];
            dat_q  <= wb.wb_dat_i;
            sel_q  <= wb.wb_sel_i;
            we_q   <= wb.wb_we_i;
            resp_q <= live_resp;
        end
    end

    wb_mem_array #(.AW(MEM_AW)) u_mem (
        .clk   (clk),
        .rst   (rst),
        .addr  (cur_adr),
        .be    (mem_be),
        .wdata (cur_dat),
        .rd_en (mem_rd),
        .rdata (rdata)
    );

    assign wb.wb_dat_o = rdata;

endmodule

// File: tb/tb_wb_slave_mem.sv
// Self-checking bench for wb_slave_mem: three instances (0, 2 and 3 wait states)
// share one stimulus bus; a directed table, corner sequences and random traffic.
module tb_wb_slave_mem;
    import wb_mem_pkg::*;

    localparam int AW   = 10;
    localparam int NDUT = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] adr, dat;
    logic [3:0]  sel;
    logic        we, cyc, stb, busy;
    int          dsel;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    wb_slave_mem_if wb0 ();
    wb_slave_mem_if wb1 ();
    wb_slave_mem_if wb2 ();

    assign wb0.wb_adr_i = adr;  assign wb0.wb_dat_i = dat;  assign wb0.wb_sel_i = sel;
    assign wb0.wb_we_i  = we;   assign wb0.wb_cyc_i = cyc & (dsel == 0);
    assign wb0.wb_stb_i = stb & (dsel == 0);
    assign wb1.wb_adr_i = adr;  assign wb1.wb_dat_i = dat;  assign wb1.wb_sel_i = sel;
    assign wb1.wb_we_i  = we;   assign wb1.wb_cyc_i = cyc & (dsel == 1);
    assign wb1.wb_stb_i = stb & (dsel == 1);
    assign wb2.wb_adr_i = adr;  assign wb2.wb_dat_i = dat;  assign wb2.wb_sel_i = sel;
    assign wb2.wb_we_i  = we;   assign wb2.wb_cyc_i = cyc & (dsel == 2);
    assign wb2.wb_stb_i = stb & (dsel == 2);

    wb_slave_mem #(.MEM_AW(AW), .WAIT_STATES(0)) u_w0 (.clk(clk), .rst(rst), .busy_i(busy), .wb(wb0.slave));
    wb_slave_mem #(.MEM_AW(AW), .WAIT_STATES(2)) u_w2 (.clk(clk), .rst(rst), .busy_i(busy), .wb(wb1.slave));
    wb_slave_mem #(.MEM_AW(AW), .WAIT_STATES(3)) u_w3 (.clk(clk), .rst(rst), .busy_i(busy), .wb(wb2.slave));

    logic [31:0] m_dat;
    logic [2:0]  m_term;  // {rty, err, ack} of the selected instance

    always_comb begin
        case (dsel)
            0: begin m_dat = wb0.wb_dat_o; m_term = {wb0.wb_rty_o, wb0.wb_err_o, wb0.wb_ack_o}; end
            1: begin m_dat = wb1.wb_dat_o; m_term = {wb1.wb_rty_o, wb1.wb_err_o, wb1.wb_ack_o}; end
            default: begin m_dat = wb2.wb_dat_o; m_term = {wb2.wb_rty_o, wb2.wb_err_o, wb2.wb_ack_o}; end
        endcase
    end

    function automatic int wait_of(input int d);
        case (d)
            0: return 0;
            1: return 2;
            default: return 3;
        endcase
    endfunction

    function automatic logic [2:0] term_of(input resp_e k);
        case (k)
            ACK: return 3'b001;
            ERR: return 3'b010;
            RTY: return 3'b100;
            default: return 3'b000;
        endcase
    endfunction

    // Reference classification written straight from the bus rules.
    function automatic resp_e ref_classify(input logic [31:0] a, input logic [3:0] s, input logic b);
        if (b) return RTY;
        if ((a % 4) != 0 || s == 4'h0 || (a & 32'h0FFF_FFFF) >= (32'd1 << (AW + 2))) return ERR;
        return ACK;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One request on instance d; starts and ends on a falling edge.
    task automatic run_txn(input int d, input logic [31:0] a, input logic [31:0] wd,
                           input logic [3:0] s, input logic w, input logic b,
                           input resp_e k, input logic [31:0] exp_rd, input string name);
        int          wt, first, cnt;
        logic [2:0]  got;
        logic [31:0] rd;
        wt = wait_of(d); first = -1; cnt = 0; got = 3'b000; rd = 32'h0;
        dsel = d; adr = a; dat = wd; sel = s; we = w; busy = b; cyc = 1'b1; stb = 1'b1;
        @(posedge clk);
        for (int c = 0; c <= wt + 2; c++) begin
            @(negedge clk);
            if (m_term != 3'b000) begin
                cnt++;
                if (first < 0) begin
                    first = c; got = m_term; rd = m_dat;
                end
                cyc = 1'b0; stb = 1'b0; busy = 1'b0;
            end
        end
        if (first < 0) rd = m_dat;
        cyc = 1'b0; stb = 1'b0; busy = 1'b0;
        check({name, " resp"},    64'(got),   64'(term_of(k)));
        check({name, " latency"}, 64'(first), 64'(wt));
        check({name, " count"},   64'(cnt),   64'd1);
        check({name, " rdata"},   64'(rd),    64'(exp_rd));
    endtask

    typedef struct {
        logic [31:0] adr;
        logic [31:0] dat;
        logic [3:0]  sel;
        logic        we;
        logic        busy;
        resp_e       kind;
        logic [31:0] rd;
    } vec_t;

    vec_t        tbl [16];
    logic [31:0] ref_mem [NDUT][16];
    logic [31:0] ref_rd  [NDUT];

    initial begin
        int          n_term;
        logic [31:0] a, wd;
        logic [3:0]  s;
        logic        w, b;
        int          wi, r;
        resp_e       k;
        logic [31:0] exp_rd;

        tbl[0]  = '{32'h0000_0010, 32'hDEADBEEF, 4'hF, 1'b1, 1'b0, ACK, 32'h0000_0000};
        tbl[1]  = '{32'h0000_0010, 32'h0,        4'hF, 1'b0, 1'b0, ACK, 32'hDEADBEEF};
        tbl[2]  = '{32'h0000_0010, 32'h0000_00AA, 4'h1, 1'b1, 1'b0, ACK, 32'hDEADBEEF};
        tbl[3]  = '{32'h0000_0010, 32'h0,        4'hF, 1'b0, 1'b0, ACK, 32'hDEADBEAA};
        tbl[4]  = '{32'h0000_0012, 32'h0,        4'hF, 1'b0, 1'b0, ERR, 32'hDEADBEAA};
        tbl[5]  = '{32'h0000_0010, 32'h1111_1111, 4'h0, 1'b1, 1'b0, ERR, 32'hDEADBEAA};
        tbl[6]  = '{32'h0000_0010, 32'h0,        4'hF, 1'b0, 1'b0, ACK, 32'hDEADBEAA};
        tbl[7]  = '{32'h0000_0010, 32'h1234_5678, 4'hF, 1'b1, 1'b1, RTY, 32'hDEADBEAA};
        tbl[8]  = '{32'h0000_0010, 32'h0,        4'hF, 1'b0, 1'b0, ACK, 32'hDEADBEAA};
        tbl[9]  = '{32'h0000_0010, 32'h1234_5678, 4'hF, 1'b1, 1'b0, ACK, 32'hDEADBEAA};
        tbl[10] = '{32'h0000_0010, 32'h0,        4'hF, 1'b0, 1'b0, ACK, 32'h1234_5678};
        tbl[11] = '{32'h0000_1000, 32'h0,        4'hF, 1'b0, 1'b0, ERR, 32'h1234_5678};
        tbl[12] = '{32'hF000_0010, 32'h0,        4'hF, 1'b0, 1'b0, ACK, 32'h1234_5678};
        tbl[13] = '{32'h0000_0FFC, 32'hCAFEF00D, 4'hF, 1'b1, 1'b0, ACK, 32'h1234_5678};
        tbl[14] = '{32'h0000_0FFC, 32'h0,        4'hF, 1'b0, 1'b0, ACK, 32'hCAFEF00D};
        tbl[15] = '{32'h0000_0010, 32'h0,        4'hF, 1'b0, 1'b1, RTY, 32'hCAFEF00D};

        rst = 1'b0; adr = '0; dat = '0; sel = '0; we = 1'b0; cyc = 1'b0; stb = 1'b0;
        busy = 1'b0; dsel = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < NDUT; d++) begin
            dsel = d;
            #1;
            check($sformatf("reset term d%0d", d), 64'(m_term), 64'd0);
            check($sformatf("reset dat d%0d", d),  64'(m_dat),  64'd0);
        end
        rst = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 16; i++)
            run_txn(1, tbl[i].adr, tbl[i].dat, tbl[i].sel, tbl[i].we, tbl[i].busy,
                    tbl[i].kind, tbl[i].rd, $sformatf("tbl[%0d]", i));

        // Reset while a write sits in WAIT: no termination, outputs cleared, memory intact.
        dsel = 1; adr = 32'h10; dat = 32'h0BADF00D; sel = 4'hF; we = 1'b1; cyc = 1'b1; stb = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("rst mid term", 64'(m_term), 64'd0);
        check("rst mid dat",  64'(m_dat),  64'd0);
        rst = 1'b1; cyc = 1'b0; stb = 1'b0;
        n_term = 0;
        repeat (4) begin
            @(negedge clk);
            if (m_term != 3'b000) n_term++;
        end
        check("rst mid no term", 64'(n_term), 64'd0);
        run_txn(1, 32'h10, 32'h0, 4'hF, 1'b0, 1'b0, ACK, 32'h1234_5678, "rst mid readback");

        // Abort on the 3-wait-state instance: stb drops one cycle after the sample.
        run_txn(2, 32'h20, 32'h55AA55AA, 4'hF, 1'b1, 1'b0, ACK, 32'h0, "abort setup");
        dsel = 2; adr = 32'h20; dat = 32'hFFFF_FFFF; sel = 4'hF; we = 1'b1; cyc = 1'b1; stb = 1'b1;
        @(posedge clk);
        @(negedge clk);
        stb = 1'b0;
        n_term = 0;
        repeat (6) begin
            @(negedge clk);
            if (m_term != 3'b000) n_term++;
        end
        cyc = 1'b0;
        check("abort no term", 64'(n_term), 64'd0);
        run_txn(2, 32'h20, 32'h0, 4'hF, 1'b0, 1'b0, ACK, 32'h55AA55AA, "abort readback");

        ref_rd[0] = 32'h0;
        ref_rd[1] = 32'h1234_5678;
        ref_rd[2] = 32'h55AA55AA;

        // Random traffic against the reference memory model.
        for (int d = 0; d < NDUT; d++) begin
            for (int i = 0; i < 16; i++) begin
                wd = $urandom;
                run_txn(d, 32'(i) << 2, wd, 4'hF, 1'b1, 1'b0, ACK, ref_rd[d],
                        $sformatf("init d%0d w%0d", d, i));
                ref_mem[d][i] = wd;
            end
            for (int i = 0; i < 60; i++) begin
                wi = $urandom_range(0, 15);
                a  = 32'(wi) << 2;
                r  = $urandom_range(0, 15);
                if (r == 0) a = a | 32'($urandom_range(1, 3));
                if (r == 1) a = a | (32'h1 << $urandom_range(12, 27));
                if (r == 2) a = a | (32'($urandom_range(1, 15)) << 28);
                s  = 4'($urandom_range(0, 15));
                b  = ($urandom_range(0, 7) == 0);
                w  = 1'($urandom_range(0, 1));
                wd = $urandom;
                k  = ref_classify(a, s, b);
                exp_rd = (k == ACK && !w) ? ref_mem[d][wi] : ref_rd[d];
                run_txn(d, a, wd, s, w, b, k, exp_rd, $sformatf("rnd d%0d #%0d", d, i));
                if (k == ACK && w) begin
                    for (int l = 0; l < 4; l++)
                        if (s[l]) ref_mem[d][wi][8*l +: 8] = wd[8*l +: 8];
                end
                if (k == ACK && !w) ref_rd[d] = ref_mem[d][wi];
            end
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
